arr_port_arbiter: RTL and testbench
===================================

// Module: arr_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing one single-port array memory (arr_* style: wen/addr/wdata, combinational rdata)
//  between NREQ synthesized kernels. Each owner cycle is exactly one memory transaction.
//  Sits between the kernel FSMs and the arr_* memory instance, replacing direct kernel-to-memory wiring.
//  Optional lock gives a requester back-to-back ownership, bounded by MAX_BURST.
// PARAMETERS
//  NREQ       2    number of requesters (2..8)
//  AW         10   memory address width
//  DW         32   memory data width (signed data, passed through unmodified)
//  MAX_BURST  16   max consecutive owner cycles under lock before a forced release (>=1)
// PORTS
//  clk         in   1         single clock, rising edge
//  rst_n       in   1         asynchronous active-low reset
//  req         in   NREQ      req[i]: requester i wants a transaction; held until grant[i] seen
//  lock        in   NREQ      lock[i]: keep ownership after the current grant cycle
//  req_wen     in   NREQ      per-requester write enable
//  req_addr    in   NREQ*AW   per-requester address, slice i = [i*AW +: AW]
//  req_wdata   in   NREQ*DW   per-requester write data, slice i = [i*DW +: DW]
//  grant       out  NREQ      one-hot registered grant; grant[i]=1 => this cycle's transaction is i's
//  rdata       out  DW        memory read data broadcast; valid for the granted requester only
//  busy        out  1         1 in OWN state
//  mem_wen     out  1         to memory write enable
//  mem_addr    out  AW        to memory address
//  mem_wdata   out  DW        to memory write data
//  mem_rdata   in   DW        from memory combinational read data
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, grant=0, busy=0, burst_cnt=0, last_owner=NREQ-1 (req 0 wins first).
//   mem_wen=0 immediately. Reset mid-transaction aborts it; no write is issued in the reset cycle.
//  State IDLE: grant=0, mem_wen=0, mem_addr=0, mem_wdata=0.
//   Any req bit set at edge -> OWN; owner = first set bit searching last_owner+1, +2, ... (mod NREQ);
//   burst_cnt=1.
//  State OWN: grant[owner]=1 for the whole cycle.
//   mem_addr/mem_wdata = owner's slices.
//   mem_wen = req_wen[owner] & req[owner]. A grant cycle with req[owner]=0 is a no-op (no write).
//  Read latency: rdata=mem_rdata combinationally in the grant cycle. Requester samples rdata at the edge ending grant.
//  Write: committed by the memory at the edge ending the grant cycle.
//  End of OWN cycle, priority order:
//   1) req[owner] & lock[owner] & burst_cnt<MAX_BURST -> stay, same owner, burst_cnt++.
//   2) else last_owner=owner. Re-arbitrate from owner+1 over current req, excluding nothing.
//      Owner loses to any other pending requester.
//      Hit -> OWN with new/same owner, burst_cnt=1. No hit -> IDLE.
//  A lone requester holding req without lock is granted every cycle (full throughput, no bubble).
//  MAX_BURST reached while others wait: forced release; locked owner re-queues behind them.
//  MAX_BURST reached with no other req: owner re-granted, burst_cnt=1.
//  Simultaneous requests: strict rotation from last_owner+1. Every requester is served within NREQ*MAX_BURST cycles.
//  grant is one-hot or zero at all times. burst_cnt is $clog2(MAX_BURST+1) bits and never wraps.
//  Requester contract: keep req/addr/wen/wdata stable from req rise until the cycle grant[i]=1.
//   Drop req on the following edge unless another transaction is wanted.
// TESTING
//  1 Reset: rst_n=0 with req=2'b11 -> grant=0, mem_wen=0 asynchronously.
//    Release -> grant=01 one edge after req sampled.
//  2 Single read: req[0], addr=5, mem holding i at i -> grant[0]=1 next cycle, rdata=5, mem_wen=0.
//  3 Write/read-back: req[1] wen=1 addr=7 wdata=-3, then read addr 7 -> rdata=-3 (signed preserved).
//  4 Contention: req=11 held 6 cycles, no lock -> grant sequence 01,10,01,10,01,10.
//  5 Lock burst: MAX_BURST=4, req0+lock0 held, req1 held -> grant 01 x4, then 10, then 01 x4.
//  6 Mid-op reset and no-op: rst_n low during a write grant -> memory location unchanged.
//    req drop during grant -> mem_wen=0 that cycle.

Source files
------------

// File: rtl/arr_port_arbiter.sv
// Round-robin arbiter sharing one single-port arr_* memory among NREQ
// kernels; one memory transaction per owner cycle, optional bounded lock.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   req/lock/req_wen       per-requester request, lock, write enable
//   req_addr/req_wdata     packed per-requester address / write data
//   grant                  one-hot registered grant (zero when idle)
//   rdata                  memory read data broadcast
//   busy                   high while a requester owns the memory
//   mem_wen/addr/wdata     to memory
//   mem_rdata              from memory (combinational read)
module arr_port_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 10,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    grant,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic               mem_wen,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  logic [0:0]      state, state_nxt;
  logic [OW-1:0]   owner, owner_nxt;
  logic [OW-1:0]   last, last_nxt;
  logic [BW-1:0]   bcnt, bcnt_nxt;
  logic [NREQ-1:0] grant_nxt;

  logic [OW-1:0]   base;
  logic [OW-1:0]   pick;
  logic            hit;
  logic            stay;

  // Search starts just after base and wraps, so base itself is
  // checked last: a releasing owner loses to any other requester.
  assign base = (state == OWN) ? owner : last;

  always_comb begin
    hit  = 1'b0;
    pick = base;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(base) + k) % NREQ;
      if (!hit && req[idx]) begin
        hit  = 1'b1;
        pick = OW'(idx);
      end
    end
  end

  assign stay = (state == OWN) && req[owner] && lock[owner]
              && (bcnt < BW'(MAX_BURST));

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    bcnt_nxt  = bcnt;
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_nxt = OWN;
          owner_nxt = pick;
          bcnt_nxt  = BW'(1);
        end
      end
      OWN: begin
        if (stay) begin
          bcnt_nxt = bcnt + BW'(1);
        end else begin
          last_nxt = owner;
          if (hit) begin
            owner_nxt = pick;
            bcnt_nxt  = BW'(1);
          end else begin
            state_nxt = IDLE;
            bcnt_nxt  = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        bcnt_nxt  = '0;
      end
    endcase
    grant_nxt = '0;
    if (state_nxt == OWN)
      grant_nxt[owner_nxt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      last  <= OW'(NREQ - 1);
      bcnt  <= '0;
      grant <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      bcnt  <= bcnt_nxt;
      grant <= grant_nxt;
    end
  end

  assign busy  = (state == OWN);
  assign rdata = mem_rdata;

  // A grant with req dropped is a no-op: address/data still
  // follow the owner but no write is issued.
  assign mem_wen = busy && req[owner] && req_wen[owner];

  assign mem_addr = busy
    ? req_addr[int'(owner)*AW +: AW] : '0;

  assign mem_wdata = busy
    ? req_wdata[int'(owner)*DW +: DW] : '0;

endmodule

// File: tb/tb_arr_port_arbiter.sv
// Directed bench for arr_port_arbiter with a behavioural
// arr_* memory (word i initialised to i).
module tb_arr_port_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int MB   = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    lock = '0;
  logic [NREQ-1:0]    req_wen = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    grant;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic               mem_wen;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  logic               init_en = 1'b0;
  logic [DW-1:0]      mem [1024];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  arr_port_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .lock(lock), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .rdata(rdata), .busy(busy),
    .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= DW'(i);
    end else if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic req_set(input int i, input logic r,
                         input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i]             = r;
    req_wen[i]         = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_all();
    req       = '0;
    lock      = '0;
    req_wen   = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic do_reset();
    clear_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [DW-1:0] NEG3 = -32'sd3;

  logic [NREQ-1:0] t4_exp [6];
  logic [NREQ-1:0] t5_exp [9];

  initial begin
    t4_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    t5_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
               2'b01, 2'b01, 2'b01, 2'b01};

    // 1: reset held with both requesting, then release
    init_en = 1'b1;
    rst_n   = 1'b0;
    req     = 2'b11;
    @(posedge clk);
    #1 init_en = 1'b0;
    @(posedge clk);
    mid();
    check("rst_grant", DW'(grant), '0);
    check("rst_wen", DW'(mem_wen), '0);
    check("rst_busy", DW'(busy), '0);
    rst_n = 1'b1;
    tick();
    mid();
    check("rel_grant", DW'(grant), 32'h1);
    check("rel_busy", DW'(busy), 32'h1);

    // 2: single read, then drop req -> no-op grant -> idle
    do_reset();
    tick();
    req_set(0, 1'b1, 1'b0, 10'd5, '0);
    tick();
    mid();
    check("rd_grant", DW'(grant), 32'h1);
    check("rd_data", rdata, 32'd5);
    check("rd_wen", DW'(mem_wen), '0);
    tick();
    req_set(0, 1'b0, 1'b0, 10'd5, '0);
    mid();
    check("noop_grant", DW'(grant), 32'h1);
    check("noop_wen", DW'(mem_wen), '0);
    tick();
    mid();
    check("idle_grant", DW'(grant), '0);
    check("idle_busy", DW'(busy), '0);
    check("idle_addr", DW'(mem_addr), '0);

    // 3: write -3 at 7 by requester 1, read back
    do_reset();
    tick();
    req_set(1, 1'b1, 1'b1, 10'd7, NEG3);
    tick();
    mid();
    check("wr_grant", DW'(grant), 32'h2);
    check("wr_wen", DW'(mem_wen), 32'h1);
    check("wr_wdata", mem_wdata, NEG3);
    tick();
    req_set(1, 1'b1, 1'b0, 10'd7, '0);
    mid();
    check("rb_grant", DW'(grant), 32'h2);
    check("rb_wen", DW'(mem_wen), '0);
    check("rb_data", rdata, NEG3);
    tick();
    req_set(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();

    // 4: contention without lock alternates every cycle
    do_reset();
    tick();
    req_set(0, 1'b1, 1'b0, 10'd1, '0);
    req_set(1, 1'b1, 1'b0, 10'd2, '0);
    for (int k = 0; k < 6; k++) begin
      tick();
      mid();
      check($sformatf("rr_grant%0d", k), DW'(grant),
            DW'(t4_exp[k]));
      check($sformatf("rr_data%0d", k), rdata,
            (t4_exp[k] == 2'b01) ? 32'd1 : 32'd2);
    end
    tick();
    clear_all();
    tick();
    tick();

    // 5: lock burst bounded by MAX_BURST=4
    do_reset();
    tick();
    req_set(0, 1'b1, 1'b0, 10'd3, '0);
    req_set(1, 1'b1, 1'b0, 10'd4, '0);
    lock = 2'b01;
    for (int k = 0; k < 9; k++) begin
      tick();
      mid();
      check($sformatf("lk_grant%0d", k), DW'(grant),
            DW'(t5_exp[k]));
    end
    tick();
    clear_all();
    tick();
    tick();

    // 6: reset mid-write aborts it
    do_reset();
    tick();
    req_set(0, 1'b1, 1'b1, 10'd9, 32'd123);
    tick();
    mid();
    check("ab_grant", DW'(grant), 32'h1);
    check("ab_wen", DW'(mem_wen), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("ab_async_wen", DW'(mem_wen), '0);
    check("ab_async_grant", DW'(grant), '0);
    check("ab_async_busy", DW'(busy), '0);
    clear_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    req_set(0, 1'b1, 1'b0, 10'd9, '0);
    tick();
    mid();
    check("ab_grant2", DW'(grant), 32'h1);
    check("ab_keep", rdata, 32'd9);
    tick();
    clear_all();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
